// File: rtl/ahb_ext_sram.sv
// AHB-Lite SRAM slave for the SoC external bus port: programmable data-phase
// wait states, byte-strobed writes, and a two-cycle ERROR for out-of-range addresses.

typedef struct packed {
    int unsigned AHBW;
    int unsigned PA_BITS;
} cvw_t;

module ahb_ext_sram #(
    parameter cvw_t        P           = '{AHBW: 64, PA_BITS: 32},
    parameter logic [63:0] BASE        = 64'h8000_0000,
    parameter int unsigned DEPTH       = 4096,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                   HCLK,
    input  logic                   reset,
    input  logic                   HSELEXT,
    input  logic [P.PA_BITS-1:0]   HADDR,
    input  logic [1:0]             HTRANS,
    input  logic                   HWRITE,
    input  logic [2:0]             HSIZE,
    input  logic                   HREADY,
    input  logic [P.AHBW-1:0]      HWDATA,
    input  logic [P.AHBW/8-1:0]    HWSTRB,
    output logic [P.AHBW-1:0]      HRDATAEXT,
    output logic                   HREADYEXT,
    output logic                   HRESPEXT
);
    localparam int unsigned BYTES = P.AHBW / 8;
    localparam int unsigned OFFW  = $clog2(BYTES);
    localparam int unsigned IDXW  = $clog2(DEPTH);
    localparam int unsigned PAW   = P.PA_BITS;

    localparam logic [PAW-1:0] BASE_A    = BASE[PAW-1:0];
    localparam logic [PAW:0]   SPAN      = (PAW + 1)'(DEPTH * BYTES);
    localparam logic [3:0]     WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [IDXW-1:0] idx_q;
    logic            wr_q;
    logic [2:0]      size_q;

    logic [P.AHBW-1:0] mem [DEPTH];

    logic [PAW-1:0] off;
    logic           inrange;
    logic           accept;
    logic           take;
    logic           ready_int;
    logic           mem_we;
    logic           unused_htrans0;

    // Subtraction wraps, so addresses below BASE land far above SPAN.
    assign off            = HADDR - BASE_A;
    assign inrange        = {1'b0, off} < SPAN;
    assign accept         = HSELEXT & HREADY & HTRANS[1];
    assign take           = accept & ready_int;
    assign mem_we         = (state_q == StData) && wr_q;
    assign unused_htrans0 = HTRANS[0];

    always_ff @(posedge HCLK or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (take) begin
                idx_q  <= off[OFFW +: IDXW];
                wr_q   <= HWRITE;
                size_q <= HSIZE;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle, StData, StErr2: begin
                state_d = StIdle;
                if (take) begin
                    if (!inrange) begin
                        state_d = StErr1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = StWait;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) state_d = StData;
                else               cnt_d   = cnt_q - 4'd1;
            end
            StErr1:  state_d = StErr2;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ready_int = 1'b1;
        HRESPEXT  = 1'b0;
        case (state_q)
            StWait: ready_int = 1'b0;
            StErr1: begin
                ready_int = 1'b0;
                HRESPEXT  = 1'b1;
            end
            StErr2:  HRESPEXT = 1'b1;
            default: ;
        endcase
        HREADYEXT = ready_int;
        HRDATAEXT = (state_q == StData && !wr_q) ? mem[idx_q] : '0;
    end

    // Commits on the closing edge of the write data phase; array is never reset.
    always_ff @(posedge HCLK) begin
        if (mem_we) begin
            for (int b = 0; b < int'(BYTES); b++) begin
                if (HWSTRB[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

    a_size_fits: assert property (@(posedge HCLK) disable iff (reset)
        (state_q == StData) |-> (size_q <= 3'(OFFW)));

endmodule
